// File: rtl/adder_seq_ctrl.sv
// Two-requester, nibble-serial adder: round-robin grant in IDLE, one 4-bit slice
// per cycle in ADD, result held in DONE until the consumer takes it.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,

    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id,

    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state_q,  state_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             id_q,     id_d;
    logic [W-1:0]     sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             valid_q,  valid_d;
    logic             last_q,   last_d;

    // ------------------------------------------------------------------
    // Arbitration: the requester that was not served last wins a tie.
    // ------------------------------------------------------------------
    logic grant_any;
    logic grant_id;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    // ------------------------------------------------------------------
    // Current nibble slice and its 5-bit sum.
    // ------------------------------------------------------------------
    logic [IDX_W+1:0] nib_shift;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum_nib;
    logic [W-1:0]     nib_mask;
    logic [W-1:0]     nib_value;

    always_comb begin
        nib_shift = {idx_q, 2'b00};
        a_nib     = 4'(a_q >> nib_shift);
        b_nib     = 4'(b_q >> nib_shift);
        sum_nib   = {1'b0, a_nib} + {1'b0, b_nib} + 5'(carry_q);
        nib_mask  = W'(4'hF) << nib_shift;
        nib_value = W'(sum_nib[3:0]) << nib_shift;
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    a_d     = grant_id ? req1_a   : req0_a;
                    b_d     = grant_id ? req1_b   : req0_b;
                    carry_d = grant_id ? req1_cin : req0_cin;
                    id_d    = grant_id;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                sum_d   = (sum_q & ~nib_mask) | nib_value;
                carry_d = sum_nib[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = sum_nib[4];
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                // Handshake returns to IDLE; the next accept is one cycle later.
                if (res_ready) begin
                    last_d  = id_q;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign res_valid = valid_q;
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
    assign busy      = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Protocol properties.
    // ------------------------------------------------------------------
    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=>
            (res_valid && $stable(res_sum) && $stable(res_cout) && $stable(res_id)));

endmodule
